e_mdu: RTL and testbench

Parametrised multi-cycle multiply/divide unit for the E stage of the pipelined MIPS core. It sits beside the E-stage ALU and executes mult/multu/div/divu/madd/msub iteratively. It owns the HI/LO register pair and serves mthi/mtlo/mfhi/mflo. It raises a busy flag that the hazard unit uses to stall dependent instructions. It also honours the exception/interrupt request so that a flushed instruction never alters HI/LO.

---
 rtl/e_mdu.sv | 138 +++++++++++++
 tb/tb_e_mdu.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - E-stage iterative multiply/divide unit owning the HI/LO pair
//
// Runs mult/multu/div/divu/madd/msub over a fixed number of busy cycles and
// serves mthi/mtlo/mfhi/mflo. The result is computed when the op is accepted and
// held in pending registers. It is committed to HI/LO on the last busy edge.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   E_MDUOp      operation code (0 NONE .. 10 MSUB, 11-15 NONE)
//   E_Start      qualifies a start-type op this cycle
//   E_Req        exception/interrupt flush of the current E instruction
//   A, B         rs / rt operands
//   E_Busy       high while an operation is in flight
//   E_HI, E_LO   committed HI / LO
//   E_MDUResult  combinational read of HI (MFHI) or LO (MFLO), else 0
module e_mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       E_MDUOp,
    input  logic             E_Start,
    input  logic             E_Req,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             E_Busy,
    output logic [WIDTH-1:0] E_HI,
    output logic [WIDTH-1:0] E_LO,
    output logic [WIDTH-1:0] E_MDUResult
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MSUB  = 4'd10;

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   pend_hi;
    logic [WIDTH-1:0]   pend_lo;
    logic               idle;
    logic               is_start_op;
    logic               is_div_op;
    logic               accept;

    assign idle        = (cnt == '0);
    assign is_div_op   = (E_MDUOp == OP_DIV) || (E_MDUOp == OP_DIVU);
    assign is_start_op = (E_MDUOp == OP_MULT) || (E_MDUOp == OP_MULTU) || is_div_op ||
                         (E_MDUOp == OP_MADD) || (E_MDUOp == OP_MSUB);
    assign accept      = E_Start && is_start_op && !E_Req && idle;

    // Products: extending to 2*WIDTH before multiplying gives the exact
    // signed/unsigned product modulo 2^(2*WIDTH).
    logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u, hilo;
    assign a_sx   = {{WIDTH{A[WIDTH-1]}}, A};
    assign b_sx   = {{WIDTH{B[WIDTH-1]}}, B};
    assign a_zx   = {{WIDTH{1'b0}}, A};
    assign b_zx   = {{WIDTH{1'b0}}, B};
    assign prod_s = a_sx * b_sx;
    assign prod_u = a_zx * b_zx;
    assign hilo   = {E_HI, E_LO};

    // Signed divide through magnitudes. The most-negative dividend has a
    // magnitude that is still representable unsigned, so MIN / -1 naturally
    // yields quotient MIN and remainder 0. A zero divisor is replaced by 1 so the
    // arithmetic is always defined; that result is discarded anyway.
    logic             b_zero, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, den_s, den_u, q_mag, r_mag, q_s, r_s, q_u, r_u;
    assign b_zero = (B == '0);
    assign a_neg  = A[WIDTH-1];
    assign b_neg  = B[WIDTH-1];
    assign a_mag  = a_neg ? (~A + WIDTH'(1)) : A;
    assign b_mag  = b_neg ? (~B + WIDTH'(1)) : B;
    assign den_s  = b_zero ? WIDTH'(1) : b_mag;
    assign den_u  = b_zero ? WIDTH'(1) : B;
    assign q_mag  = a_mag / den_s;
    assign r_mag  = a_mag % den_s;
    assign q_s    = (a_neg ^ b_neg) ? (~q_mag + WIDTH'(1)) : q_mag;
    assign r_s    = a_neg ? (~r_mag + WIDTH'(1)) : r_mag;
    assign q_u    = A / den_u;
    assign r_u    = A % den_u;

    logic [2*WIDTH-1:0] nxt_hilo;
    always_comb begin
        nxt_hilo = hilo;
        case (E_MDUOp)
            OP_MULT:  nxt_hilo = prod_s;
            OP_MULTU: nxt_hilo = prod_u;
            OP_MADD:  nxt_hilo = hilo + prod_s;
            OP_MSUB:  nxt_hilo = hilo - prod_s;
            OP_DIV:   if (!b_zero) nxt_hilo = {r_s, q_s};
            OP_DIVU:  if (!b_zero) nxt_hilo = {r_u, q_u};
            default:  nxt_hilo = hilo;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            E_Busy  <= 1'b0;
            E_HI    <= '0;
            E_LO    <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
        end else if (!idle) begin
            // In-flight ops ignore new starts, moves and flush requests.
            cnt    <= cnt - CW'(1);
            E_Busy <= (cnt != CW'(1));
            if (cnt == CW'(1)) begin
                E_HI <= pend_hi;
                E_LO <= pend_lo;
            end
        end else if (accept) begin
            {pend_hi, pend_lo} <= nxt_hilo;
            cnt    <= is_div_op ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            E_Busy <= 1'b1;
        end else if (!E_Req) begin
            if (E_MDUOp == OP_MTHI) E_HI <= A;
            if (E_MDUOp == OP_MTLO) E_LO <= A;
        end
    end

    always_comb begin
        E_MDUResult = '0;
        if (E_MDUOp == OP_MFHI) E_MDUResult = E_HI;
        if (E_MDUOp == OP_MFLO) E_MDUResult = E_LO;
    end
endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - scoreboard bench for e_mdu (default and 16-bit instances)
module tb_e_mdu;
    localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
    localparam logic [3:0] MTHI = 4'd5, MTLO = 4'd6, MFHI = 4'd7, MFLO = 4'd8;
    localparam logic [3:0] MADD = 4'd9, MSUB = 4'd10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rn1 = 1'b0, st1 = 1'b0, rq1 = 1'b0, busy1;
    logic [3:0]  op1 = NONE;
    logic [31:0] a1 = '0, b1 = '0, hi1, lo1, res1;

    logic        rn2 = 1'b0, st2 = 1'b0, rq2 = 1'b0, busy2;
    logic [3:0]  op2 = NONE;
    logic [15:0] a2 = '0, b2 = '0, hi2, lo2, res2;

    e_mdu dut1 (
        .clk(clk), .reset_n(rn1), .E_MDUOp(op1), .E_Start(st1), .E_Req(rq1),
        .A(a1), .B(b1), .E_Busy(busy1), .E_HI(hi1), .E_LO(lo1), .E_MDUResult(res1)
    );

    e_mdu #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut2 (
        .clk(clk), .reset_n(rn2), .E_MDUOp(op2), .E_Start(st2), .E_Req(rq2),
        .A(a2), .B(b2), .E_Busy(busy2), .E_HI(hi2), .E_LO(lo2), .E_MDUResult(res2)
    );

    typedef struct {int cyc; logic [31:0] hi; logic [31:0] lo;} done_t;
    typedef struct {logic busy; logic [31:0] hi; logic [31:0] lo; logic [31:0] res;} snap_t;

    done_t dq1[$], dq2[$];
    snap_t sq1[$], sq2[$];
    logic  sn1 = 1'b0, sn2 = 1'b0;
    int    bc1 = 0, bc2 = 0;
    int    n_cmp = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: a completion is the falling edge of busy; a snapshot is a
    // cycle flagged by the stimulus.
    always @(negedge clk) begin
        done_t d;
        snap_t s;
        if (busy1) bc1++;
        else if (bc1 > 0) begin
            if (dq1.size() == 0) chk("d1_unexpected_done", 32'(bc1), 32'd0);
            else begin
                d = dq1.pop_front();
                chk("d1_busy_cycles", 32'(bc1), 32'(d.cyc));
                chk("d1_hi", hi1, d.hi);
                chk("d1_lo", lo1, d.lo);
            end
            bc1 = 0;
        end
        if (sn1) begin
            s = sq1.pop_front();
            chk("s1_busy", {31'd0, busy1}, {31'd0, s.busy});
            chk("s1_hi", hi1, s.hi);
            chk("s1_lo", lo1, s.lo);
            chk("s1_result", res1, s.res);
        end
        if (busy2) bc2++;
        else if (bc2 > 0) begin
            if (dq2.size() == 0) chk("d2_unexpected_done", 32'(bc2), 32'd0);
            else begin
                d = dq2.pop_front();
                chk("d2_busy_cycles", 32'(bc2), 32'(d.cyc));
                chk("d2_hi", {16'd0, hi2}, d.hi);
                chk("d2_lo", {16'd0, lo2}, d.lo);
            end
            bc2 = 0;
        end
        if (sn2) begin
            s = sq2.pop_front();
            chk("s2_busy", {31'd0, busy2}, {31'd0, s.busy});
            chk("s2_hi", {16'd0, hi2}, s.hi);
            chk("s2_lo", {16'd0, lo2}, s.lo);
            chk("s2_result", {16'd0, res2}, s.res);
        end
    end

    task automatic exp1(input int c, input logic [31:0] h, input logic [31:0] l);
        done_t d;
        d.cyc = c; d.hi = h; d.lo = l;
        dq1.push_back(d);
    endtask

    task automatic exp2(input int c, input logic [31:0] h, input logic [31:0] l);
        done_t d;
        d.cyc = c; d.hi = h; d.lo = l;
        dq2.push_back(d);
    endtask

    task automatic start1(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic req);
        op1 = op; a1 = a; b1 = b; st1 = 1'b1; rq1 = req;
        @(posedge clk); #1;
        op1 = NONE; st1 = 1'b0; rq1 = 1'b0;
    endtask

    task automatic start2(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        op2 = op; a2 = a; b2 = b; st2 = 1'b1;
        @(posedge clk); #1;
        op2 = NONE; st2 = 1'b0;
    endtask

    task automatic mt1(input logic [3:0] op, input logic [31:0] a, input logic req);
        op1 = op; a1 = a; rq1 = req;
        @(posedge clk); #1;
        op1 = NONE; rq1 = 1'b0;
    endtask

    task automatic snap1(input logic [3:0] op, input logic bz, input logic [31:0] h,
                         input logic [31:0] l, input logic [31:0] r);
        snap_t s;
        s.busy = bz; s.hi = h; s.lo = l; s.res = r;
        sq1.push_back(s);
        op1 = op; sn1 = 1'b1;
        @(posedge clk); #1;
        op1 = NONE; sn1 = 1'b0;
    endtask

    task automatic snap2(input logic [3:0] op, input logic bz, input logic [31:0] h,
                         input logic [31:0] l, input logic [31:0] r);
        snap_t s;
        s.busy = bz; s.hi = h; s.lo = l; s.res = r;
        sq2.push_back(s);
        op2 = op; sn2 = 1'b1;
        @(posedge clk); #1;
        op2 = NONE; sn2 = 1'b0;
    endtask

    task automatic wait_idle1();
        int g = 0;
        while (busy1 && g < 40) begin
            @(posedge clk); #1;
            g++;
        end
        if (busy1) chk("d1_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_idle2();
        int g = 0;
        while (busy2 && g < 40) begin
            @(posedge clk); #1;
            g++;
        end
        if (busy2) chk("d2_idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #100000;
        chk("watchdog", 32'd1, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rn1 = 1'b1; rn2 = 1'b1;

        // Reset state
        snap1(MFHI, 1'b0, 32'h0, 32'h0, 32'h0);
        snap1(MFLO, 1'b0, 32'h0, 32'h0, 32'h0);

        // MULT -2*3; a start arriving while busy must be ignored
        exp1(5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        start1(MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        start1(MULTU, 32'd5, 32'd5, 1'b0);
        wait_idle1();
        snap1(MFHI, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFF);

        // Division
        exp1(10, 32'd1, 32'd3);
        start1(DIVU, 32'd7, 32'd2, 1'b0);
        wait_idle1();
        exp1(10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        start1(DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_idle1();

        // Moves, divide by zero, MIN / -1
        mt1(MTHI, 32'h1234, 1'b0);
        mt1(MTLO, 32'h5678, 1'b0);
        snap1(MFLO, 1'b0, 32'h1234, 32'h5678, 32'h5678);
        exp1(10, 32'h1234, 32'h5678);
        start1(DIV, 32'h99, 32'h0, 1'b0);
        wait_idle1();
        snap1(NONE, 1'b0, 32'h1234, 32'h5678, 32'h0);
        exp1(10, 32'h0, 32'h8000_0000);
        start1(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_idle1();

        // Accumulate
        mt1(MTLO, 32'hFFFF_FFFF, 1'b0);
        mt1(MTHI, 32'h0, 1'b0);
        exp1(5, 32'h1, 32'h0);
        start1(MADD, 32'd1, 32'd1, 1'b0);
        wait_idle1();
        exp1(5, 32'h0, 32'hFFFF_FFFE);
        start1(MSUB, 32'd2, 32'd1, 1'b0);
        wait_idle1();

        // Flush: start and move both suppressed
        start1(MULT, 32'd3, 32'd3, 1'b1);
        mt1(MTHI, 32'hDEAD, 1'b1);
        snap1(MFLO, 1'b0, 32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFE);

        // Flush mid-op does not cancel; MTHI while busy ignored
        exp1(5, 32'h1, 32'h0);
        start1(MULT, 32'h1_0000, 32'h1_0000, 1'b0);
        mt1(MTHI, 32'hBAD, 1'b1);
        mt1(MTHI, 32'hBAD, 1'b1);
        mt1(MTHI, 32'hBAD, 1'b0);
        wait_idle1();
        snap1(MFHI, 1'b0, 32'h1, 32'h0, 32'h1);

        // 16-bit instance, 1-cycle multiply, 3-cycle divide
        exp2(1, 32'hFFFE, 32'h0001);
        start2(MULTU, 16'hFFFF, 16'hFFFF);
        wait_idle2();
        snap2(MFHI, 1'b0, 32'hFFFE, 32'h0001, 32'hFFFE);
        exp2(3, 32'h2, 32'hE);
        start2(DIVU, 16'd100, 16'd7);
        wait_idle2();
        exp2(1, 32'h0, 32'hF);
        start2(MULTU, 16'd3, 16'd5);
        wait_idle2();

        // Reset pulse in the second busy cycle of a DIVU
        exp2(2, 32'h0, 32'h0);
        start2(DIVU, 16'd100, 16'd7);
        @(posedge clk); #1;
        @(negedge clk); #1;
        rn2 = 1'b0;
        @(posedge clk); #1;
        rn2 = 1'b1;
        @(posedge clk); #1;
        snap2(MFLO, 1'b0, 32'h0, 32'h0, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("d1_pending_left", 32'(dq1.size()), 32'd0);
        chk("d2_pending_left", 32'(dq2.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
